apb_master_bridge: RTL and testbench

Upstream stage of the APB SRAM slave interface. It converts a single-outstanding valid/ready command channel (from a CPU/DMA-side requester) into compliant APB3/APB4 SETUP/ACCESS transfers, and returns read data and error status on a valid/ready response channel. It rejects unaligned addresses without touching the bus. A watchdog terminates ACCESS phases that never see PREADY.

---
 rtl/apb_master_bridge_if.sv | 47 ++++
 rtl/apb_master_bridge.sv | 113 +++++++++++
 tb/tb_apb_master_bridge.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Bundles the command, response and APB signals of apb_master_bridge.
// The master modport is the bridge's view; slave is the requester/APB-target side.
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH+1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;
    logic [3:0]            cmd_strb_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    logic [ADDR_WIDTH+1:0] paddr_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [3:0]            pstrb_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i,
        output paddr_o, psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i,
        input  paddr_o, psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready command -> APB3/4 SETUP/ACCESS bridge with
// unaligned-address rejection and an ACCESS-phase watchdog.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic pclk_i,
    input  logic prst_n_i,
    apb_master_bridge_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int          TO_LIM  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [15:0] TO_LAST = TO_LIM[15:0];

    state_t                r_state;
    logic [15:0]           r_wdog;
    logic [ADDR_WIDTH+1:0] r_paddr;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [3:0]            r_pstrb;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  w_timeout;

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wdog == TO_LAST);

    // Gated by reset so the ready output is low while reset is held.
    assign bus.cmd_ready_o   = prst_n_i && (r_state == IDLE);
    assign bus.paddr_o       = r_paddr;
    assign bus.psel_o        = r_psel;
    assign bus.penable_o     = r_penable;
    assign bus.pwrite_o      = r_pwrite;
    assign bus.pstrb_o       = r_pstrb;
    assign bus.pwdata_o      = r_pwdata;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_rdata_o   = r_rsp_rdata;
    assign bus.rsp_err_o     = r_rsp_err;
    assign bus.rsp_timeout_o = r_rsp_timeout;

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            r_state       <= IDLE;
            r_wdog        <= '0;
            r_paddr       <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pstrb       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.cmd_valid_i) begin
                    if (bus.cmd_addr_i[1:0] != 2'b00) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_state       <= RESP;
                    end else begin
                        r_paddr  <= bus.cmd_addr_i;
                        r_pwrite <= bus.cmd_write_i;
                        r_pwdata <= bus.cmd_wdata_i;
                        r_pstrb  <= bus.cmd_write_i ? bus.cmd_strb_i : 4'b0000;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_wdog    <= '0;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // A completing pready takes priority over a simultaneous timeout.
                    if (bus.pready_i) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata_i;
                        r_rsp_err     <= bus.pslverr_i;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (w_timeout) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                RESP: if (bus.rsp_ready_i) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: aligned/unaligned transfers, wait
// states, watchdog abort, slave error, response back-pressure and reset abort.
module tb_apb_master_bridge;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    apb_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .pclk_i  (clk),
        .prst_n_i(rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int lat, psel_n, pen_n, addr_bad;
    logic [3:0] strb_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command, act as an APB slave inserting `waits` wait states,
    // and return once rsp_valid_o is seen (sampled on negedges).
    task automatic run(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input int waits, input logic serr,
                       input logic [31:0] rd);
        int acc;
        acc = 0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = wd;
        bus.cmd_strb_i  = strb;
        chk("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
        lat = 0; psel_n = 0; pen_n = 0; addr_bad = 0; strb_seen = 4'h0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.psel_o) begin
                psel_n++;
                strb_seen = bus.pstrb_o;
                if (bus.paddr_o !== addr) addr_bad++;
            end
            if (bus.penable_o) begin
                pen_n++;
                acc++;
            end
            bus.pready_i  = bus.penable_o && (acc > waits);
            bus.prdata_i  = rd;
            bus.pslverr_i = serr && bus.pready_i;
            if (bus.rsp_valid_o) break;
            if (lat >= 64) begin
                chk("rsp_wait_bound", 32'd0, 32'd1);
                break;
            end
        end
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
    endtask

    // Hold rsp_ready_i low for `hold` cycles, then complete the handshake.
    task automatic drain(input int hold);
        logic [31:0] d;
        logic e, t, stable;
        d = bus.rsp_rdata_o; e = bus.rsp_err_o; t = bus.rsp_timeout_o;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (bus.rsp_rdata_o !== d || bus.rsp_err_o !== e || bus.rsp_timeout_o !== t ||
                bus.rsp_valid_o !== 1'b1 || bus.cmd_ready_o !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) chk("rsp_stable", 32'(stable), 32'd1);
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk("rsp_valid_clr", 32'(bus.rsp_valid_o), 32'd0);
        chk("cmd_ready_back", 32'(bus.cmd_ready_o), 32'd1);
    endtask

    initial begin
        bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
        bus.cmd_wdata_i = '0;   bus.cmd_strb_i = '0;   bus.rsp_ready_i = 1'b0;
        bus.prdata_i = '0;      bus.pready_i = 1'b0;   bus.pslverr_i = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("rst_psel",      32'(bus.psel_o), 32'd0);
        chk("rst_penable",   32'(bus.penable_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_paddr",     32'(bus.paddr_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.cmd_ready_o), 32'd1);

        // Aligned write, zero wait states.
        run(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
        chk("wr_lat",    32'(lat), 32'd3);
        chk("wr_psel_n", 32'(psel_n), 32'd2);
        chk("wr_pen_n",  32'(pen_n), 32'd1);
        chk("wr_pstrb",  32'(strb_seen), 32'hF);
        chk("wr_addr",   32'(addr_bad), 32'd0);
        chk("wr_err",    32'(bus.rsp_err_o), 32'd0);
        chk("wr_rdata",  bus.rsp_rdata_o, 32'h0);
        chk("wr_pwdata", bus.pwdata_o, 32'hDEADBEEF);
        drain(0);

        // Read with two wait states.
        run(1'b0, 12'h004, 32'h0, 4'hF, 2, 1'b0, 32'hDEADBEEF);
        chk("rd_lat",   32'(lat), 32'd5);
        chk("rd_pen_n", 32'(pen_n), 32'd3);
        chk("rd_pstrb", 32'(strb_seen), 32'h0);
        chk("rd_addr",  32'(addr_bad), 32'd0);
        chk("rd_rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
        chk("rd_err",   32'(bus.rsp_err_o), 32'd0);
        drain(0);

        // Unaligned: rejected without bus activity.
        run(1'b1, 12'h006, 32'h12345678, 4'hF, 0, 1'b0, 32'h0);
        chk("ua_lat",    32'(lat), 32'd1);
        chk("ua_psel_n", 32'(psel_n), 32'd0);
        chk("ua_err",    32'(bus.rsp_err_o), 32'd1);
        chk("ua_to",     32'(bus.rsp_timeout_o), 32'd0);
        chk("ua_rdata",  bus.rsp_rdata_o, 32'h0);
        chk("ua_paddr_kept", 32'(bus.paddr_o), 32'h004);
        drain(0);

        // Slave never ready: watchdog aborts after 8 ACCESS cycles.
        run(1'b0, 12'h010, 32'h0, 4'h0, 1000, 1'b0, 32'hCAFEF00D);
        chk("to_pen_n", 32'(pen_n), 32'd8);
        chk("to_lat",   32'(lat), 32'd10);
        chk("to_err",   32'(bus.rsp_err_o), 32'd1);
        chk("to_flag",  32'(bus.rsp_timeout_o), 32'd1);
        chk("to_rdata", bus.rsp_rdata_o, 32'h0);
        chk("to_psel",  32'(bus.psel_o), 32'd0);
        drain(0);

        // Slave error on a write, then response back-pressure.
        run(1'b1, 12'h008, 32'h0BADF00D, 4'h3, 0, 1'b1, 32'h0);
        chk("se_err",   32'(bus.rsp_err_o), 32'd1);
        chk("se_to",    32'(bus.rsp_timeout_o), 32'd0);
        chk("se_pstrb", 32'(strb_seen), 32'h3);
        drain(5);

        // Reset during ACCESS of a read.
        @(negedge clk);
        bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = 12'h00C;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("ra_in_access", 32'(bus.penable_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_psel",      32'(bus.psel_o), 32'd0);
        chk("ra_penable",   32'(bus.penable_o), 32'd0);
        chk("ra_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ra_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);

        run(1'b0, 12'h00C, 32'h0, 4'h0, 1, 1'b0, 32'hA5A55A5A);
        chk("ar_lat",   32'(lat), 32'd4);
        chk("ar_rdata", bus.rsp_rdata_o, 32'hA5A55A5A);
        chk("ar_err",   32'(bus.rsp_err_o), 32'd0);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
